// File: rtl/parity_pitch_pkg.sv
// parity_pitch_pkg
//   Shared definitions for the G.729 pitch-parity encoder and its decoder-side
//   checker: FSM state encoding and the fixed iteration count.
package parity_pitch_pkg;

  // Number of shift/accumulate iterations over index bits 7..2.
  localparam int PITCH_PARITY_ITER = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ACCUM = 3'd3,
    ST_FINAL = 3'd4
  } pp_state_e;

endpackage

// File: rtl/parity_pitch_if.sv
// parity_pitch_if
//   Request/result handshake plus the operand/result buses to the shared
//   basic-op add and shr units.
//   slave  : the parity engine (consumes start/pitch_index/add_in/shr_in).
//   master : the surrounding logic (issues requests, owns the op units).
interface parity_pitch_if;
  logic        start;
  logic [15:0] pitch_index;
  logic        done;
  logic [15:0] parity;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_in;
  logic [15:0] shr_a;
  logic [15:0] shr_b;
  logic [15:0] shr_in;

  modport slave (
    input  start, pitch_index, add_in, shr_in,
    output done, parity, add_a, add_b, shr_a, shr_b
  );

  modport master (
    output start, pitch_index, add_in, shr_in,
    input  done, parity, add_a, add_b, shr_a, shr_b
  );
endinterface

// File: rtl/parity_pitch_pipe.sv
// parity_pitch_pipe
//   Wrapper that binds parity_pitch to the shared basic-op units.
//   Ports: clk, reset (sync, active-high), start, pitch_index[15:0] in;
//          done, parity[15:0] out.
// parity_pitch_add : 16-bit signed saturating add (ITU add).
// parity_pitch_shr : 16-bit arithmetic shift right (ITU shr); a negative
//                    shift amount shifts left with saturation.

module parity_pitch_add (
  input  logic [15:0] var1_i,
  input  logic [15:0] var2_i,
  output logic [15:0] sum_o
);
  logic signed [16:0] s;
  always_comb begin
    s = $signed({var1_i[15], var1_i}) + $signed({var2_i[15], var2_i});
    if (s > 17'sd32767)       sum_o = 16'h7FFF;
    else if (s < -17'sd32768) sum_o = 16'h8000;
    else                      sum_o = s[15:0];
  end
endmodule

module parity_pitch_shr (
  input  logic [15:0] var1_i,
  input  logic [15:0] var2_i,
  output logic [15:0] res_o
);
  logic signed [15:0] v1;
  logic signed [15:0] v2;
  logic        [4:0]  nsh;
  logic signed [31:0] wide;
  always_comb begin
    v1    = $signed(var1_i);
    v2    = $signed(var2_i);
    nsh   = '0;
    wide  = '0;
    res_o = '0;
    if (v2 < 16'sd0) begin
      // Left shift; anything beyond 16 saturates a non-zero value anyway.
      if (v2 < -16'sd16) nsh = 5'd16;
      else               nsh = 5'(-v2);
      wide = $signed({{16{v1[15]}}, v1}) <<< nsh;
      if (wide > 32'sd32767)       res_o = 16'h7FFF;
      else if (wide < -32'sd32768) res_o = 16'h8000;
      else                         res_o = wide[15:0];
    end else if (v2 >= 16'sd15) begin
      res_o = {16{v1[15]}};
    end else begin
      res_o = v1 >>> v2[3:0];
    end
  end
endmodule

module parity_pitch_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pitch_index,
  output logic        done,
  output logic [15:0] parity
);
  parity_pitch_if bus_if ();

  assign bus_if.start       = start;
  assign bus_if.pitch_index = pitch_index;
  assign done               = bus_if.done;
  assign parity             = bus_if.parity;

  parity_pitch_add u_add (
    .var1_i (bus_if.add_a),
    .var2_i (bus_if.add_b),
    .sum_o  (bus_if.add_in)
  );

  parity_pitch_shr u_shr (
    .var1_i (bus_if.shr_a),
    .var2_i (bus_if.shr_b),
    .res_o  (bus_if.shr_in)
  );

  parity_pitch u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );
endmodule

// File: rtl/parity_pitch.sv
// parity_pitch
//   G.729 encoder pitch-parity generator over bits 7..2 of the pitch index.
//   Arithmetic goes through the shared add/shr units so results stay
//   bit-exact with the reference basic ops.
//   Ports: clk, reset (sync, active-high), bus (parity_pitch_if.slave):
//     start/pitch_index in, done/parity out, add_a/add_b -> add_in,
//     shr_a/shr_b -> shr_in.
module parity_pitch
  import parity_pitch_pkg::*;
#(
  // Fixed by the standard; keep at the package value.
  parameter int ITER = PITCH_PARITY_ITER
) (
  input  logic           clk,
  input  logic           reset,
  parity_pitch_if.slave  bus
);

  localparam logic [2:0] LAST = 3'(ITER - 1);

  pp_state_e   state_q;
  logic [15:0] idx_q;
  logic [15:0] temp_q;
  logic [15:0] sum_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        done_q;
  logic [15:0] parity_q;

  assign cnt_d      = cnt_q + 3'd1;
  assign bus.done   = done_q;
  assign bus.parity = parity_q;

  // Operand buses are a pure decode of registered state; forced to zero
  // while reset is asserted and in states that do not use an op unit.
  always_comb begin
    bus.add_a = '0;
    bus.add_b = '0;
    bus.shr_a = '0;
    bus.shr_b = '0;
    if (!reset) begin
      unique case (state_q)
        ST_INIT: begin
          bus.shr_a = idx_q;
          bus.shr_b = 16'd1;
        end
        ST_SHIFT: begin
          bus.shr_a = temp_q;
          bus.shr_b = 16'd1;
        end
        ST_ACCUM: begin
          bus.add_a = sum_q;
          bus.add_b = {15'b0, temp_q[0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      temp_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      parity_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_q   <= bus.pitch_index;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          temp_q  <= bus.shr_in;
          sum_q   <= 16'd1;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          temp_q  <= bus.shr_in;
          state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          sum_q   <= bus.add_in;
          cnt_q   <= cnt_d;
          state_q <= (cnt_q == LAST) ? ST_FINAL : ST_SHIFT;
        end
        ST_FINAL: begin
          parity_q <= sum_q & 16'h0001;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_pitch.sv
// tb_parity_pitch
//   Directed + randomized bench for parity_pitch (wired to the shared op
//   units) and parity_pitch_pipe, checked against an ITU-style model and the
//   decoder parity check.
module tb_parity_pitch;
  import parity_pitch_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  parity_pitch_if bus ();

  logic        p_done;
  logic [15:0] p_parity;

  parity_pitch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  parity_pitch_add u_add (
    .var1_i (bus.add_a),
    .var2_i (bus.add_b),
    .sum_o  (bus.add_in)
  );

  parity_pitch_shr u_shr (
    .var1_i (bus.shr_a),
    .var2_i (bus.shr_b),
    .res_o  (bus.shr_in)
  );

  parity_pitch_pipe u_pipe (
    .clk         (clk),
    .reset       (reset),
    .start       (bus.start),
    .pitch_index (bus.pitch_index),
    .done        (p_done),
    .parity      (p_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ITU Parity_Pitch on plain signed integers.
  function automatic logic [15:0] itu_parity(input logic [15:0] idx);
    int temp;
    int sum;
    temp = $signed(idx);
    temp = temp >>> 1;
    sum  = 1;
    for (int i = 0; i < 6; i++) begin
      temp = temp >>> 1;
      sum  = sum + (temp & 1);
    end
    return 16'(sum & 1);
  endfunction

  // Decoder-side check: 0 means the parity bit is consistent.
  function automatic int dec_check(input logic [15:0] idx, input logic [15:0] par);
    int s;
    s = 1 + int'(par);
    for (int b = 2; b <= 7; b++) s = s + int'(idx[b]);
    return s & 1;
  endfunction

  // One request; wait for done (bounded), check latency, parity, pipe copy,
  // decoder check and that done drops after one cycle with parity held.
  task automatic run(input logic [15:0] idx, input string tag);
    int          lat;
    logic [15:0] exp;
    exp = itu_parity(idx);
    bus.pitch_index = idx;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pitch_index = 16'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'd15);
    chk({tag, "/parity"}, 32'(bus.parity), 32'(exp));
    chk({tag, "/pipe"}, {15'b0, p_done, p_parity}, {15'b0, 1'b1, exp});
    chk({tag, "/decchk"}, 32'(dec_check(idx, bus.parity)), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, {15'b0, bus.done, bus.parity}, {15'b0, 1'b0, exp});
  endtask

  initial begin
    int lat;
    int dcount;
    bus.start       = 1'b0;
    bus.pitch_index = '0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst/done",   32'(bus.done), 32'd0);
    chk("rst/parity", 32'(bus.parity), 32'd0);
    chk("rst/ops",    {bus.add_a, bus.add_b} | {bus.shr_a, bus.shr_b}, 32'd0);
    chk("rst/state",  32'(dut.state_q), 32'(ST_IDLE));

    // Directed values
    run(16'd0,    "idx0");
    run(16'd4,    "idx4");
    run(16'd28,   "idx28");
    run(16'd255,  "idx255");
    run(16'h0103, "idx0103");
    run(16'hFFFF, "idxFFFF");
    chk("idle/ops", {bus.add_a, bus.add_b} | {bus.shr_a, bus.shr_b}, 32'd0);

    // start held high, index switched mid-run, then accepted in done cycle
    bus.pitch_index = 16'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (lat == 5) bus.pitch_index = 16'd4;
      @(posedge clk); #1;
      lat++;
    end
    chk("held/latency", 32'(lat), 32'd15);
    chk("held/parity",  32'(bus.parity), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b/latency", 32'(lat), 32'd15);
    chk("b2b/parity",  32'(bus.parity), 32'd0);
    @(posedge clk); #1;

    // Leave parity at 1, then abort a run in ACCUM
    run(16'd0, "pre_abort");
    bus.pitch_index = 16'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort/in_accum", 32'(dut.state_q), 32'(ST_ACCUM));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort/state",  32'(dut.state_q), 32'(ST_IDLE));
    chk("abort/parity", 32'(bus.parity), 32'd0);
    dcount = 0;
    repeat (20) begin
      if (bus.done) dcount++;
      @(posedge clk); #1;
    end
    chk("abort/no_done", 32'(dcount), 32'd0);
    run(16'd4, "post_abort");

    // Randomized indices
    for (int i = 0; i < 30; i++) run(16'($urandom), "rand");

    // Full sweep of the 8-bit index range
    for (int i = 0; i < 256; i++) run(16'(i), "sweep");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
